// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg
//   Shared types and constants for the PLL reset sequencer.
//   - state_t   : sequencer states
//   - RETRY_W   : width of the saturating retry counter
//   - max3      : helper used to size the shared state counter
package pll_reset_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned RETRY_W = 4;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer with asynchronous active-low clear.
//   Also used by downstream clock domains to synchronize the deassertion
//   of sys_rst_n.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low clear (both flops -> 0)
//   d     in  asynchronous input
//   q     out synchronized output
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Reset sequencer in front of the PLL wrapper. Pulses the PLL reset,
//   waits for lock, requires lock to be stable for STABLE_CYCLES and only
//   then releases the system reset. Re-resets the PLL on lock timeout or
//   on lock loss while running.
// Ports:
//   clk         in  free-running board reference clock
//   rst_n       in  asynchronous active-low reset
//   pll_locked  in  PLL locked indication (asynchronous to clk)
//   pll_rst     out PLL reset, active-high
//   sys_rst_n   out system reset, active-low, released only in RUN
//   ready       out high in RUN
//   retry_count out saturating count of lock timeouts
//   lock_lost   out sticky: lock dropped while in RUN
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic               lock_lost
);

  localparam int unsigned CNT_W =
    $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             timeout;
  logic             loss;
  logic             pll_rst_d;
  logic             sys_rst_n_d;
  logic             ready_d;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLL_RST;
    end else begin
      state <= next_state;
    end
  end

  // Shared counter: cleared on every transition; idle in RUN since no
  // RUN exit depends on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (state != RUN) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state logic. In WAIT_LOCK lock is tested before the timeout so
  // a lock arriving on the timeout edge wins.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    loss       = 1'b0;
    unique case (state)
      PLL_RST: begin
        if (cnt == P_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          next_state = STABLE;
        end else if (cnt == T_LAST) begin
          next_state = PLL_RST;
          timeout    = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == S_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state = PLL_RST;
          loss       = 1'b1;
        end
      end
      default: next_state = PLL_RST;
    endcase
  end

  // Output decode from next_state; registering it gives outputs that track
  // the state register exactly while coming straight from flops.
  always_comb begin
    pll_rst_d   = (next_state == PLL_RST);
    sys_rst_n_d = (next_state == RUN);
    ready_d     = (next_state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      ready       <= 1'b0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      sys_rst_n <= sys_rst_n_d;
      ready     <= ready_d;
      if (timeout && (retry_count != RETRY_MAX)) begin
        retry_count <= retry_count + RETRY_W'(1);
      end
      if (loss) begin
        lock_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//   Scoreboard bench for pll_reset_seq with P=4, T=32, S=8. Each scenario
//   pushes expected output vectors tagged with the edge number (counted
//   from reset release) and a negedge monitor pops and compares them.
module tb_pll_reset_seq;

  localparam int unsigned P = 4;
  localparam int unsigned T = 32;
  localparam int unsigned S = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [3:0] retry_count;
  logic       lock_lost;

  pll_reset_seq #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .retry_count(retry_count),
    .lock_lost  (lock_lost)
  );

  always #10 clk = ~clk;

  // Edge 1 = first rising edge with rst_n high.
  int unsigned edge_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    int unsigned at;
    logic        pll_rst;
    logic        sys_rst_n;
    logic        ready;
    logic [3:0]  retry;
    logic        lock_lost;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_at(input int unsigned at, input logic pr,
                           input logic sr, input logic rdy,
                           input logic [3:0] rc, input logic ll,
                           input string tag);
    exp_t e;
    e.at = at; e.pll_rst = pr; e.sys_rst_n = sr; e.ready = rdy;
    e.retry = rc; e.lock_lost = ll; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        if (e.at < edge_n) begin
          check($sformatf("%s.missed@%0d", e.tag, e.at), edge_n, e.at);
        end else begin
          check($sformatf("%s.pll_rst@%0d", e.tag, e.at), pll_rst, e.pll_rst);
          check($sformatf("%s.sys_rst_n@%0d", e.tag, e.at), sys_rst_n, e.sys_rst_n);
          check($sformatf("%s.ready@%0d", e.tag, e.at), ready, e.ready);
          check($sformatf("%s.retry@%0d", e.tag, e.at), retry_count, e.retry);
          check($sformatf("%s.lock_lost@%0d", e.tag, e.at), lock_lost, e.lock_lost);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, ".pll_rst"},   pll_rst,     1);
    check({tag, ".sys_rst_n"}, sys_rst_n,   0);
    check({tag, ".ready"},     ready,       0);
    check({tag, ".retry"},     retry_count, 0);
    check({tag, ".lock_lost"}, lock_lost,   0);
  endtask

  task automatic hold_reset(input logic lk, input string tag);
    rst_n      = 1'b0;
    pll_locked = lk;
    repeat (2) @(negedge clk);
    check_reset_vals(tag);
  endtask

  task automatic wait_edge(input int unsigned n);
    int unsigned guard = 0;
    while (edge_n < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != n) check($sformatf("wait_edge%0d", n), edge_n, n);
  endtask

  task automatic drain(input int unsigned budget, input string tag);
    int unsigned guard = 0;
    while (sb.size() > 0 && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check({tag, ".drain"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic push_bringup(input string tag);
    expect_at(P - 1,     1, 0, 0, 0, 0, tag);
    expect_at(P,         0, 0, 0, 0, 0, tag);
    expect_at(P + S,     0, 0, 0, 0, 0, tag);
    expect_at(P + S + 1, 0, 1, 1, 0, 0, tag);
    expect_at(P + S + 8, 0, 1, 1, 0, 0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    // 1. Normal bring-up with lock present from the start
    hold_reset(1'b1, "s1_rst");
    push_bringup("s1");
    @(negedge clk); rst_n = 1'b1;
    drain(100, "s1");

    // 2. Timeouts, retry saturation at 15
    hold_reset(1'b0, "s2_rst");
    expect_at(35,  0, 0, 0, 4'd0,  0, "s2");
    expect_at(36,  1, 0, 0, 4'd1,  0, "s2");
    expect_at(40,  0, 0, 0, 4'd1,  0, "s2");
    expect_at(72,  1, 0, 0, 4'd2,  0, "s2");
    expect_at(540, 1, 0, 0, 4'd15, 0, "s2");
    expect_at(575, 0, 0, 0, 4'd15, 0, "s2");
    expect_at(576, 1, 0, 0, 4'd15, 0, "s2");
    @(negedge clk); rst_n = 1'b1;
    drain(700, "s2");

    // 3. One-cycle lock glitch in mid-STABLE
    hold_reset(1'b1, "s3_rst");
    expect_at(13, 0, 0, 0, 0, 0, "s3");
    expect_at(18, 0, 0, 0, 0, 0, "s3");
    expect_at(19, 0, 1, 1, 0, 0, "s3");
    @(negedge clk); rst_n = 1'b1;
    wait_edge(7);  pll_locked = 1'b0;
    wait_edge(8);  pll_locked = 1'b1;
    drain(100, "s3");

    // 4. Lock loss in RUN; relock during PLL_RST is ignored
    hold_reset(1'b1, "s4_rst");
    expect_at(17, 0, 1, 1, 0, 0, "s4");
    expect_at(18, 1, 0, 0, 0, 1, "s4");
    expect_at(21, 1, 0, 0, 0, 1, "s4");
    expect_at(22, 0, 0, 0, 0, 1, "s4");
    expect_at(30, 0, 0, 0, 0, 1, "s4");
    expect_at(31, 0, 1, 1, 0, 1, "s4");
    expect_at(33, 0, 1, 1, 0, 1, "s4");
    @(negedge clk); rst_n = 1'b1;
    wait_edge(15); pll_locked = 1'b0;
    wait_edge(18); pll_locked = 1'b1;
    drain(100, "s4");

    // 5. Async reset mid-RUN, between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("s5_async");
    @(negedge clk);
    push_bringup("s5");
    rst_n = 1'b1;
    drain(100, "s5");

    // 6. Lock reaches locked_s exactly on the timeout edge
    hold_reset(1'b0, "s6_rst");
    expect_at(35, 0, 0, 0, 0, 0, "s6");
    expect_at(36, 0, 0, 0, 0, 0, "s6");
    expect_at(37, 0, 0, 0, 0, 0, "s6");
    expect_at(43, 0, 0, 0, 0, 0, "s6");
    expect_at(44, 0, 1, 1, 0, 0, "s6");
    @(negedge clk); rst_n = 1'b1;
    wait_edge(33); pll_locked = 1'b1;
    drain(100, "s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
